// File: rtl/sar_conv_sequencer.sv
// Successive-approximation conversion sequencer.
// Runs a sample window, then resolves one result bit per clock, MSB first,
// using the comparator, and finally latches the finished code into DataOut.
// Conversions can run one at a time or back to back, and Abort cancels
// a conversion that is in progress.
module sar_conv_sequencer #(
    parameter int DATA       = 8,
    parameter int SAMPLE_CYC = 4,
    parameter int CNT_W      = 4
) (
    input  logic            ClockT,
    input  logic            ResetN,
    input  logic            Start,
    input  logic            Continuous,
    input  logic            Abort,
    input  logic            CompIn,
    output logic [1:0]      StateP,
    output logic [DATA-1:0] SAROut,
    output logic            SampleEn,
    output logic            Busy,
    output logic            Done,
    output logic [DATA-1:0] DataOut
);

    // The encoding doubles as the phase code sent downstream.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_SAMPLE  = 2'b01,
        S_CONVERT = 2'b10,
        S_DONE    = 2'b11
    } StateT;

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_TOP     = CNT_W'(DATA - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [DATA-1:0]  ONE_D       = DATA'(1);
    localparam logic [DATA-1:0]  MSB_TRIAL   = ONE_D << (DATA - 1);

    StateT           stateReg;
    StateT           stateNext;
    logic [CNT_W-1:0] cntReg;
    logic [CNT_W-1:0] cntNext;
    logic [DATA-1:0]  sarReg;
    logic [DATA-1:0]  sarNext;
    logic [DATA-1:0]  dataReg;
    logic [DATA-1:0]  dataNext;
    logic [DATA-1:0]  bitMask;
    logic [DATA-1:0]  resolved;

    // State, counter, trial code and result registers; async reset clears everything.
    always_ff @(posedge ClockT or negedge ResetN) begin
        if (!ResetN) begin
            stateReg <= S_IDLE;
            cntReg   <= '0;
            sarReg   <= '0;
            dataReg  <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            sarReg   <= sarNext;
            dataReg  <= dataNext;
        end
    end

    // Next-state logic: in CONVERT the counter is the index of the bit under trial.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        sarNext   = sarReg;
        dataNext  = dataReg;
        bitMask   = ONE_D << cntReg;
        resolved  = sarReg;
        case (stateReg)
            S_IDLE: begin
                if (Start && !Abort) begin
                    stateNext = S_SAMPLE;
                    cntNext   = '0;
                    sarNext   = '0;
                end
            end
            S_SAMPLE: begin
                if (Abort) begin
                    stateNext = S_IDLE;
                    cntNext   = '0;
                    sarNext   = '0;
                end else if (cntReg == SAMPLE_LAST) begin
                    stateNext = S_CONVERT;
                    cntNext   = BIT_TOP;
                    sarNext   = MSB_TRIAL;
                end else begin
                    cntNext = cntReg + CNT_ONE;
                end
            end
            S_CONVERT: begin
                if (Abort) begin
                    stateNext = S_IDLE;
                    cntNext   = '0;
                    sarNext   = '0;
                end else begin
                    resolved = CompIn ? sarReg : (sarReg & ~bitMask);
                    if (cntReg != '0) begin
                        sarNext = resolved | (bitMask >> 1);
                        cntNext = cntReg - CNT_ONE;
                    end else begin
                        sarNext   = resolved;
                        dataNext  = resolved;
                        stateNext = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cntNext = '0;
                if (Abort) begin
                    stateNext = S_IDLE;
                    sarNext   = '0;
                end else if (Continuous) begin
                    stateNext = S_SAMPLE;
                    sarNext   = '0;
                end else begin
                    stateNext = S_IDLE;
                end
            end
            default: begin
                stateNext = S_IDLE;
                cntNext   = '0;
                sarNext   = '0;
            end
        endcase
    end

    assign StateP   = stateReg;
    assign SAROut   = sarReg;
    assign DataOut  = dataReg;
    assign SampleEn = (stateReg == S_SAMPLE);
    assign Busy     = (stateReg == S_SAMPLE) || (stateReg == S_CONVERT);
    assign Done     = (stateReg == S_DONE);

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with default parameters and an
// ideal comparator that models a fixed analog input vin.
module tb_sar_conv_sequencer;

    logic       ClockT;
    logic       ResetN;
    logic       Start;
    logic       Continuous;
    logic       Abort;
    logic       CompIn;
    logic [1:0] StateP;
    logic [7:0] SAROut;
    logic       SampleEn;
    logic       Busy;
    logic       Done;
    logic [7:0] DataOut;

    logic [7:0] vin;

    int vectorCount = 0;
    int missCount   = 0;

    typedef struct {
        logic [7:0] vin;
        bit         rePulseConv;
        bit         rePulseDone;
        bit         dropCont;
        bit         checkTrials;
        logic [7:0] expData;
    } VecT;

    VecT        vecs[5];
    logic [7:0] trialsA5[8];

    sar_conv_sequencer #(
        .DATA(8),
        .SAMPLE_CYC(4),
        .CNT_W(4)
    ) dut (
        .ClockT(ClockT),
        .ResetN(ResetN),
        .Start(Start),
        .Continuous(Continuous),
        .Abort(Abort),
        .CompIn(CompIn),
        .StateP(StateP),
        .SAROut(SAROut),
        .SampleEn(SampleEn),
        .Busy(Busy),
        .Done(Done),
        .DataOut(DataOut)
    );

    // Ideal comparator: keep the trial bit while the input is at or above the DAC code.
    assign CompIn = (vin >= SAROut);

    // Free-running conversion clock.
    initial ClockT = 1'b0;
    always #5 ClockT = ~ClockT;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge ClockT);
        #1;
    endtask

    // Steps until Done is seen (bounded); reports cycles taken and whether IDLE appeared.
    task automatic waitDone(output int cyc, output bit sawIdle);
        bit seen;
        seen    = 1'b0;
        sawIdle = 1'b0;
        cyc     = 0;
        while (!seen && cyc < 40) begin
            stepCycle();
            cyc++;
            if (StateP == 2'b00) sawIdle = 1'b1;
            if (Done) seen = 1'b1;
        end
    endtask

    // One complete conversion driven from IDLE, with optional disturbances.
    task automatic applyStimulus(input VecT v);
        int         doneCyc;
        int         convCyc;
        int         n;
        logic [7:0] trials[$];
        logic [7:0] got;
        doneCyc    = -1;
        convCyc    = 0;
        vin        = v.vin;
        Continuous = v.dropCont;
        Start      = 1'b1;
        stepCycle();
        Start = 1'b0;
        checkOutput("stateAfterStart", StateP, 2'b01);
        checkOutput("sampleEnAfterStart", SampleEn, 1'b1);
        n = 1;
        while (n <= 40 && doneCyc < 0) begin
            Start = (v.rePulseConv && convCyc == 3);
            stepCycle();
            if (StateP == 2'b10) begin
                convCyc++;
                trials.push_back(SAROut);
                if (v.dropCont) Continuous = 1'b0;
            end
            if (Done) doneCyc = n;
            n++;
        end
        Start = 1'b0;
        checkOutput("doneLatency", doneCyc, 12);
        checkOutput("convertCycles", convCyc, 8);
        checkOutput("dataOut", DataOut, v.expData);
        checkOutput("sarAtDone", SAROut, v.expData);
        checkOutput("busyAtDone", Busy, 1'b0);
        if (v.rePulseDone) Start = 1'b1;
        stepCycle();
        Start = 1'b0;
        checkOutput("doneWidth", Done, 1'b0);
        checkOutput("idleAfterDone", StateP, 2'b00);
        checkOutput("sarHeldInIdle", SAROut, v.expData);
        if (v.checkTrials) begin
            for (int i = 0; i < 8; i++) begin
                got = (i < trials.size()) ? trials[i] : 8'hxx;
                checkOutput($sformatf("trial%0d", i), got, trialsA5[i]);
            end
        end
    endtask

    // Fail-safe so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc;
        bit  sawIdle;
        int  donePulses;

        vecs[0] = '{vin: 8'hA5, rePulseConv: 1'b0, rePulseDone: 1'b0, dropCont: 1'b0, checkTrials: 1'b1, expData: 8'hA5};
        vecs[1] = '{vin: 8'h00, rePulseConv: 1'b0, rePulseDone: 1'b0, dropCont: 1'b0, checkTrials: 1'b0, expData: 8'h00};
        vecs[2] = '{vin: 8'hFF, rePulseConv: 1'b0, rePulseDone: 1'b0, dropCont: 1'b0, checkTrials: 1'b0, expData: 8'hFF};
        vecs[3] = '{vin: 8'h3C, rePulseConv: 1'b1, rePulseDone: 1'b1, dropCont: 1'b0, checkTrials: 1'b0, expData: 8'h3C};
        vecs[4] = '{vin: 8'h5A, rePulseConv: 1'b0, rePulseDone: 1'b0, dropCont: 1'b1, checkTrials: 1'b0, expData: 8'h5A};
        trialsA5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        ResetN     = 1'b0;
        Start      = 1'b0;
        Continuous = 1'b0;
        Abort      = 1'b0;
        vin        = 8'h00;
        #1;
        checkOutput("resetState", StateP, 2'b00);
        checkOutput("resetOutputs", {SAROut, SampleEn, Busy, Done, DataOut}, 0);
        repeat (2) @(posedge ClockT);
        @(negedge ClockT);
        ResetN = 1'b1;
        stepCycle();
        checkOutput("idleAfterReset", StateP, 2'b00);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Back-to-back conversions: 13 cycles apart with no IDLE in between.
        vin        = 8'h10;
        Continuous = 1'b1;
        Start      = 1'b1;
        stepCycle();
        Start = 1'b0;
        waitDone(cyc, sawIdle);
        checkOutput("contFirstLatency", cyc, 12);
        checkOutput("contFirstData", DataOut, 8'h10);
        vin = 8'hEF;
        waitDone(cyc, sawIdle);
        checkOutput("contSpacing", cyc, 13);
        checkOutput("contNoIdle", sawIdle, 1'b0);
        checkOutput("contSecondData", DataOut, 8'hEF);
        Continuous = 1'b0;
        stepCycle();
        checkOutput("contStopIdle", StateP, 2'b00);

        // Abort on the third CONVERT cycle.
        vin   = 8'h77;
        Start = 1'b1;
        stepCycle();
        Start = 1'b0;
        repeat (6) stepCycle();
        checkOutput("abortPreState", StateP, 2'b10);
        Abort = 1'b1;
        stepCycle();
        Abort = 1'b0;
        checkOutput("abortState", StateP, 2'b00);
        checkOutput("abortSar", SAROut, 8'h00);
        checkOutput("abortBusy", {Busy, SampleEn}, 2'b00);
        checkOutput("abortDataKept", DataOut, 8'hEF);
        donePulses = 0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (Done) donePulses++;
        end
        checkOutput("abortNoDone", donePulses, 0);

        // Start together with Abort in IDLE must not launch a conversion.
        Start = 1'b1;
        Abort = 1'b1;
        stepCycle();
        checkOutput("startAbortIdle1", StateP, 2'b00);
        stepCycle();
        checkOutput("startAbortIdle2", StateP, 2'b00);
        Start = 1'b0;
        Abort = 1'b0;
        stepCycle();
        checkOutput("startAbortData", DataOut, 8'hEF);

        // Asynchronous reset in the middle of SAMPLE, released between edges.
        vin   = 8'h99;
        Start = 1'b1;
        stepCycle();
        Start = 1'b0;
        repeat (2) stepCycle();
        checkOutput("preResetSample", StateP, 2'b01);
        #2;
        ResetN = 1'b0;
        #1;
        checkOutput("midResetState", StateP, 2'b00);
        checkOutput("midResetOutputs", {SAROut, SampleEn, Busy, Done, DataOut}, 0);
        @(negedge ClockT);
        #2;
        ResetN = 1'b1;
        stepCycle();
        checkOutput("postResetIdle", StateP, 2'b00);
        applyStimulus('{vin: 8'h99, rePulseConv: 1'b0, rePulseDone: 1'b0, dropCont: 1'b0, checkTrials: 1'b0, expData: 8'h99});

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
